// File: rtl/bascomp_pkg.sv
// Shared types and constants for the basic computer control path.
// Sequence counter width/limits, state encoding and the reg/IO opcode.
package bascomp_pkg;

  localparam int SEQ_W = 4;
  localparam logic [SEQ_W-1:0] SEQ_MAX = 4'd15;
  localparam logic [2:0] OP_REGIO = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_INDIRECT,
    ST_EXECUTE,
    ST_INTERRUPT
  } state_e;

endpackage

// File: rtl/t_decoder.sv
// 4-to-16 one-hot decoder turning the sequence count into T0..T15.
// Purely combinational so the T signals track the counter directly.
module t_decoder
  import bascomp_pkg::*;
(
  input  logic [SEQ_W-1:0] seq,
  output logic [15:0]      t
);

  // one-hot select of the current T state
  always_comb begin
    t      = '0;
    t[seq] = 1'b1;
  end

endmodule

// File: rtl/timing_control.sv
// Instruction-cycle timing controller driving the sequence counter.
// Define TIMING_CONTROL_INT_EN to include the interrupt cycle.
module timing_control
  import bascomp_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [SEQ_W-1:0] seq,
  input  logic [2:0]       ir_op,
  input  logic             ir_i,
  input  logic             exec_done,
  input  logic             halt_req,
  input  logic             int_req,
  output logic             sc_inc,
  output logic             sc_clr,
  output logic [15:0]      t,
  output logic [7:0]       d,
  output logic             i_flag,
  output logic             r_flag,
  output logic             ind_read,
  output logic             ien_clr,
  output logic             running,
  output logic             err
);

  state_e     state_q, state_d;
  logic [7:0] d_q, d_d;
  logic       i_q, i_d;
  logic       r_q, r_d;
  logic       err_q, err_d;

  t_decoder u_tdec (
    .seq (seq),
    .t   (t)
  );

`ifndef TIMING_CONTROL_INT_EN
  logic unused_int;
  assign unused_int = int_req;
`endif

  assign running = (state_q != ST_IDLE);
  assign d       = d_q;
  assign i_flag  = i_q;
  assign r_flag  = r_q;
  assign err     = err_q;

  // next state, counter control and latched fields
  always_comb begin
    state_d  = state_q;
    d_d      = d_q;
    i_d      = i_q;
    r_d      = r_q;
    err_d    = err_q;
    sc_inc   = 1'b0;
    sc_clr   = 1'b0;
    ind_read = 1'b0;
    ien_clr  = 1'b0;
`ifdef TIMING_CONTROL_INT_EN
    if (running && (seq > 4'd2) && int_req) begin
      r_d = 1'b1;
    end
`endif
    unique case (state_q)
      ST_IDLE: begin
        sc_clr = 1'b1;
        if (start && (seq == '0)) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        sc_inc = (seq < 4'd2);
        if (seq == 4'd1) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        sc_inc     = 1'b1;
        d_d        = '0;
        d_d[ir_op] = 1'b1;
        i_d        = ir_i;
        state_d    = (ir_op == OP_REGIO) ?
                     ST_EXECUTE : ST_INDIRECT;
      end
      ST_INDIRECT: begin
        sc_inc   = 1'b1;
        ind_read = i_q;
        state_d  = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (exec_done) begin
          sc_clr = 1'b1;
          if (halt_req) begin
            state_d = ST_IDLE;
`ifdef TIMING_CONTROL_INT_EN
          end else if (r_q) begin
            state_d = ST_INTERRUPT;
`endif
          end else begin
            state_d = ST_FETCH;
          end
        end else if (seq == SEQ_MAX) begin
          sc_clr  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_FETCH;
        end else begin
          sc_inc = 1'b1;
        end
      end
`ifdef TIMING_CONTROL_INT_EN
      ST_INTERRUPT: begin
        sc_inc = (seq < 4'd2);
        if (seq == 4'd2) begin
          sc_clr  = 1'b1;
          ien_clr = 1'b1;
          r_d     = 1'b0;
          state_d = ST_FETCH;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and latched-field registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      d_q     <= '0;
      i_q     <= 1'b0;
      r_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      i_q     <= i_d;
      r_q     <= r_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/timing_control.md
# timing_control

Instruction-cycle timing controller for the basic computer. It sits directly upstream of the 4-bit sequence counter, which increments on the negative clock edge. The controller drives the counter's `inc`/`clr` inputs, reads the counter's `sequence` value back, and decodes it into timing signals T0–T15. It also sequences the fetch, decode, indirect, execute and interrupt phases, and latches the decoded opcode and the indirect bit for the datapath.

## Interface
- No parameters.
- `clk`  in  1  system clock; state updates on the rising edge, the counter advances on the falling edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  leave IDLE and begin fetching.
- `seq`  in  4  current counter value, from counter `sequence`.
- `ir_op`  in  3  IR[14:12].
- `ir_i`  in  1  IR[15], indirect bit.
- `exec_done`  in  1  datapath reports the current T is the instruction's last.
- `halt_req`  in  1  HLT executed; qualified by `exec_done`.
- `int_req`  in  1  IEN & (FGI | FGO).
- `sc_inc`  out  1  to counter `inc`.
- `sc_clr`  out  1  to counter `clr`.
- `t`  out  16  one-hot decode of `seq`.
- `d`  out  8  one-hot opcode, latched in DECODE.
- `i_flag`  out  1  latched indirect bit.
- `r_flag`  out  1  interrupt-cycle pending/active.
- `ind_read`  out  1  perform indirect read this T (INDIRECT & `i_flag`).
- `ien_clr`  out  1  one-cycle pulse clearing IEN.
- `running`  out  1  state ≠ IDLE.
- `err`  out  1  sticky sequence-overrun flag.

## Operation
- States: IDLE, FETCH, DECODE, INDIRECT, EXECUTE, INTERRUPT.
- `sc_inc` and `sc_clr` are a combinational function of state, `seq` and `exec_done`. The two are never both 1.
- IDLE: `sc_clr`=1.
  - If `start`=1 and `seq`==0 → FETCH.
  - If `start`=1 and `seq`≠0 → remain in IDLE.
- FETCH: `sc_inc`=1 at `seq`==0 and at `seq`==1. At `seq`==1 → DECODE.
- DECODE (`seq`==2):
  - Latch `d` = onehot(`ir_op`) and `i_flag` = `ir_i`; `sc_inc`=1.
  - `ir_op`==7 → EXECUTE.
  - Otherwise → INDIRECT.
- INDIRECT (`seq`==3): `sc_inc`=1; `ind_read`=`i_flag`. Next state EXECUTE.
- EXECUTE:
  - `exec_done`=0: `sc_inc`=1.
  - `exec_done`=1: `sc_clr`=1. Next state, by priority:
    1. `halt_req` → IDLE.
    2. `r_flag` → INTERRUPT.
    3. Otherwise → FETCH.
- Interrupt detect: in any running state with `seq`∉{0,1,2} and `int_req`=1, set `r_flag`.
- INTERRUPT (`seq` 0..2):
  - `sc_inc`=1 at `seq`=0 and at `seq`=1.
  - At `seq`==2: `sc_clr`=1, `ien_clr`=1, clear `r_flag`, → FETCH.
- Overrun: EXECUTE with `seq`==15 and `exec_done`=0:
  - `sc_clr`=1 instead of `sc_inc`.
  - Set `err`; → FETCH.
  - `err` is cleared only by reset.
- Inputs outside their phase are ignored:
  - `exec_done` outside EXECUTE.
  - `start` outside IDLE.
  - `halt_req` without `exec_done`.
- `halt_req`=1 together with a pending `r_flag` → IDLE. `r_flag` is retained and is served after the next restart.

## Timing
- One T state per clock period: the controller samples `seq` on the rising edge, and the counter applies `sc_inc`/`sc_clr` on the next falling edge.
- `t` is purely combinational from `seq`, with zero latency.
- `d` and `i_flag` update on the rising edge ending DECODE and hold until the next DECODE.
- `ien_clr` is high for exactly one cycle.
- Reset (asynchronous, in any state, including mid-instruction):
  - State → IDLE.
  - `d`=0, `i_flag`=0, `r_flag`=0, `err`=0.
  - Hence `running`=0, `sc_inc`=0, `ind_read`=0, `ien_clr`=0, `sc_clr`=1.
  - `t` follows `seq`.
- Minimum instruction length:
  - Register/IO instruction: 4 cycles (T0–T3).
  - Memory-reference instruction: 5 cycles (T0–T4).

## Configuration
- `TIMING_CONTROL_INT_EN` defined: interrupt detection and the INTERRUPT state are present.
- Undefined:
  - `int_req` is ignored; `r_flag` and `ien_clr` are tied 0.
  - INTERRUPT state is removed; EXECUTE completion chooses only between IDLE and FETCH.

## Structure
- Shared package `bascomp_pkg` holds:
  - the state enum;
  - `OP_REGIO` = 3'd7;
  - `SEQ_W` = 4 and `SEQ_MAX` = 15.
- One sub-module, `t_decoder`: 4-to-16 one-hot decoder, instantiated once for `t`.

## Test plan
- Reset released, then `start`=1 for one cycle → `sc_clr` high in IDLE; FETCH entered with `seq`=0; `t` steps 0x0001→0x0002→0x0004.
- `ir_op`=2, `ir_i`=1, `exec_done` at `seq`=5 → `d`=0x04, `ind_read`=1 at T3, `sc_clr` at T5, next cycle `seq`=0 in FETCH.
- `ir_op`=7, `exec_done`+`halt_req` at T3 → IDLE, `running`=0, `sc_clr`=1.
- `int_req` pulse at T4, `exec_done` at T5 → `r_flag`=1; INTERRUPT T0–T2; `ien_clr` one pulse at T2; `r_flag` back to 0; FETCH.
- `exec_done` held 0 through `seq`=15 → `sc_clr`=1 at T15, `err`=1, FETCH; `err` stays 1 until `reset_n`=0.
- `reset_n` low during EXECUTE at T4 → immediate IDLE, `d`=0, `i_flag`=0, `sc_inc`=0, `sc_clr`=1.
